// File: rtl/frontend_cmd_queue.sv
// Frontend command queue: buffers interconnect requests and presents them to the
// backend as translated row/column commands in strict FIFO order. Requests with an
// illegal data type are consumed, dropped and flagged with a one-cycle error pulse.
module frontend_cmd_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned COL_BITS = 4,
  parameter int unsigned ROW_BITS = 6
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic [19:0]                    in_req,
  output logic                           in_ready,
  output logic                           out_valid,
  output logic [3+ROW_BITS+COL_BITS-1:0] out_cmd,
  output logic [4:0]                     out_req_id,
  output logic [1:0]                     out_core_num,
  input  logic                           out_ready,
  output logic [$clog2(DEPTH):0]         count,
  output logic                           err_illegal
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two in 2..16");
  end
  if (ROW_BITS + COL_BITS != 10) begin : g_bad_addr_split
    $error("ROW_BITS + COL_BITS must equal the 10-bit request address width");
  end

  // Stored entry: already-translated backend command plus its return tags.
  typedef struct packed {
    logic                op_type;
    logic [1:0]          data_type;
    logic [ROW_BITS-1:0] row_addr;
    logic [COL_BITS-1:0] col_addr;
    logic [4:0]          req_id;
    logic [1:0]          core_num;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;
  logic            r_err;

  logic            w_in_op;
  logic [1:0]      w_in_dtype;
  logic [9:0]      w_in_addr;
  logic [4:0]      w_in_id;
  logic [1:0]      w_in_core;
  logic            w_illegal;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  entry_t          w_entry;
  entry_t          w_head;

  assign w_in_op    = in_req[19];
  assign w_in_dtype = in_req[18:17];
  assign w_in_addr  = in_req[16:7];
  assign w_in_id    = in_req[6:2];
  assign w_in_core  = in_req[1:0];

  assign in_ready  = (r_count < CntW'(DEPTH));
  assign out_valid = (r_count != '0);

  assign w_illegal = (w_in_dtype == 2'b11);
  assign w_accept  = in_valid && in_ready;
  // Illegal requests are consumed from upstream but never written.
  assign w_push    = w_accept && !w_illegal;
  assign w_pop     = out_valid && out_ready;

  // Address split into row/column fields at push time.
  always_comb begin
    w_entry           = '0;
    w_entry.op_type   = w_in_op;
    w_entry.data_type = w_in_dtype;
    w_entry.row_addr  = w_in_addr[9:COL_BITS];
    w_entry.col_addr  = w_in_addr[COL_BITS-1:0];
    w_entry.req_id    = w_in_id;
    w_entry.core_num  = w_in_core;
  end

  // Outputs come straight from the head register; no path from in_req.
  assign w_head       = r_mem[r_rptr];
  assign out_cmd      = {w_head.op_type, w_head.data_type, w_head.row_addr, w_head.col_addr};
  assign out_req_id   = w_head.req_id;
  assign out_core_num = w_head.core_num;
  assign count        = r_count;
  assign err_illegal  = r_err;

  // Entry storage: written at the tail on a legal push, never reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  // Pointers, occupancy and error pulse; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_accept && w_illegal;
      if (w_push) begin
        r_wptr <= r_wptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_frontend_cmd_queue.sv
// Self-checking bench for frontend_cmd_queue (DEPTH=4, 6/4 row/column split).
module tb_frontend_cmd_queue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [19:0] in_req;
  logic        in_ready;
  logic        out_valid;
  logic [12:0] out_cmd;
  logic [4:0]  out_req_id;
  logic [1:0]  out_core_num;
  logic        out_ready;
  logic [2:0]  count;
  logic        err_illegal;

  frontend_cmd_queue #(
    .DEPTH   (4),
    .COL_BITS(4),
    .ROW_BITS(6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_req      (in_req),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_cmd     (out_cmd),
    .out_req_id  (out_req_id),
    .out_core_num(out_core_num),
    .out_ready   (out_ready),
    .count       (count),
    .err_illegal (err_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  int          model_cnt = 0;
  logic [19:0] q_exp[$];
  logic [4:0]  popped_ids[$];
  logic        obs_in_ready, obs_out_valid, exp_in_ready, exp_out_valid, popped, exp_err;
  logic [19:0] obs_data, exp_data;

  function automatic logic [19:0] mk_req(logic op, logic [1:0] dt, logic [9:0] addr,
                                         logic [4:0] id, logic [1:0] core);
    return {op, dt, addr, id, core};
  endfunction

  // Expected head image {op, dtype, row, col, id, core} for a request.
  function automatic logic [19:0] xlate(logic [19:0] r);
    logic [9:0] addr;
    addr = r[16:7];
    return {r[19], r[18:17], addr[9:4], addr[3:0], r[6:2], r[1:0]};
  endfunction

  // One clock: sample DUT before the edge, advance the reference model, step the edge.
  task automatic tick();
    #1;
    obs_in_ready  = in_ready;
    obs_out_valid = out_valid;
    obs_data      = {out_cmd, out_req_id, out_core_num};
    exp_in_ready  = (model_cnt < 4);
    exp_out_valid = (model_cnt != 0);
    popped        = exp_out_valid && out_ready;
    exp_err       = in_valid && exp_in_ready && (in_req[18:17] == 2'b11);
    exp_data      = '0;
    if (popped) begin
      exp_data = q_exp.pop_front();
      model_cnt--;
    end
    if (in_valid && exp_in_ready && !exp_err) begin
      q_exp.push_back(xlate(in_req));
      model_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_req = '0; model_cnt = 0;
    #12;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (err_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_illegal); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_pass_through();
    in_req = mk_req(1'b1, 2'b00, 10'h2A5, 5'd3, 2'd1); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++; if (obs_in_ready !== 1'b1) begin n_fail++; $display("FAIL pt_first_push_ready: got %b expected 1", obs_in_ready); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pt_out_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_cmd !== 13'h12A5) begin n_fail++; $display("FAIL pt_out_cmd: got %h expected 12a5", out_cmd); end
    n_checks++; if (out_req_id !== 5'd3) begin n_fail++; $display("FAIL pt_req_id: got %0d expected 3", out_req_id); end
    n_checks++; if (out_core_num !== 2'd1) begin n_fail++; $display("FAIL pt_core: got %0d expected 1", out_core_num); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL pt_count1: got %0d expected 1", count); end
    tick();
    n_checks++; if (popped && obs_data !== exp_data) begin n_fail++; $display("FAIL pt_pop_data: got %h expected %h", obs_data, exp_data); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL pt_count0: got %0d expected 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pt_drained: got %b expected 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_req   = mk_req(1'(i), 2'(i % 3), 10'(37 * i + 5), 5'(10 + i), 2'(i));
      tick();
      n_checks++; if (obs_in_ready !== exp_in_ready) begin n_fail++; $display("FAIL fill_in_ready[%0d]: got %b expected %b", i, obs_in_ready, exp_in_ready); end
    end
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d expected 4", count); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready: got %b expected 0", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (obs_out_valid !== 1'b1 || obs_data !== exp_data) begin n_fail++; $display("FAIL fill_order[%0d]: got %b/%h expected 1/%h", i, obs_out_valid, obs_data, exp_data); end
      if (i == 0) begin
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_reassert: got %b expected 1", in_ready); end
      end
      n_checks++; if (count !== 3'(model_cnt)) begin n_fail++; $display("FAIL fill_drain_count[%0d]: got %0d expected %0d", i, count, model_cnt); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_illegal();
    in_valid = 1'b1; in_req = mk_req(1'b0, 2'b11, 10'h155, 5'd7, 2'd2);
    tick();
    in_valid = 1'b0;
    n_checks++; if (obs_in_ready !== 1'b1) begin n_fail++; $display("FAIL ill_in_ready: got %b expected 1", obs_in_ready); end
    n_checks++; if (err_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_err_pulse: got %b expected 1", err_illegal); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL ill_count: got %0d expected 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ill_out_valid: got %b expected 0", out_valid); end
    tick();
    n_checks++; if (err_illegal !== 1'b0) begin n_fail++; $display("FAIL ill_err_clear: got %b expected 0", err_illegal); end
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0; in_valid = 1'b1; in_req = mk_req(1'b0, 2'b01, 10'h011, 5'd20, 2'd0);
    tick();
    out_ready = 1'b1; in_req = mk_req(1'b1, 2'b10, 10'h3FE, 5'd21, 2'd3);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL sim1_count: got %0d expected 1", count); end
    n_checks++; if (obs_data !== exp_data) begin n_fail++; $display("FAIL sim1_pop_data: got %h expected %h", obs_data, exp_data); end
    n_checks++; if (out_req_id !== 5'd21) begin n_fail++; $display("FAIL sim1_new_head: got %0d expected 21", out_req_id); end
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_req = mk_req(1'(i), 2'(i), 10'(100 + i), 5'(22 + i), 2'(i));
      tick();
    end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL sim4_fill: got %0d expected 4", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_req = mk_req(1'(i + 1), 2'((i + 1) % 3), 10'(200 + 7 * i), 5'(25 + i), 2'(3 - i));
      tick();
      n_checks++; if (obs_in_ready !== exp_in_ready) begin n_fail++; $display("FAIL sim_in_ready[%0d]: got %b expected %b", i, obs_in_ready, exp_in_ready); end
      n_checks++; if (obs_data !== exp_data) begin n_fail++; $display("FAIL sim_order[%0d]: got %h expected %h", i, obs_data, exp_data); end
      n_checks++; if (count !== 3'(model_cnt)) begin n_fail++; $display("FAIL sim_count[%0d]: got %0d expected %0d", i, count, model_cnt); end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8 && model_cnt > 0; i++) begin
      tick();
      n_checks++; if (obs_data !== exp_data) begin n_fail++; $display("FAIL sim_drain[%0d]: got %h expected %h", i, obs_data, exp_data); end
    end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL sim_empty: got %0d expected 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    popped_ids.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = (i < 10);
      in_req   = mk_req(1'(i), 2'(i % 3), 10'(i * 61), 5'(i), 2'(i));
      tick();
      if (obs_out_valid && out_ready) popped_ids.push_back(obs_data[6:2]);
      if (popped) begin
        n_checks++; if (obs_data !== exp_data) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, obs_data, exp_data); end
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (popped_ids.size() != 10) begin n_fail++; $display("FAIL wrap_pop_count: got %0d expected 10", popped_ids.size()); end
    for (int i = 0; i < 10 && i < popped_ids.size(); i++) begin
      n_checks++; if (popped_ids[i] !== 5'(i)) begin n_fail++; $display("FAIL wrap_id[%0d]: got %0d expected %0d", i, popped_ids[i], i); end
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_req = mk_req(1'b0, 2'b00, 10'(i * 3), 5'(i), 2'd0);
      tick();
    end
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL mr_pre_count: got %0d expected 3", count); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL mr_async_count: got %0d expected 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_async_valid: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mr_async_ready: got %b expected 1", in_ready); end
    model_cnt = 0;
    q_exp.delete();
    // Push attempted across an edge while still in reset must not land.
    in_valid = 1'b1; out_ready = 1'b1; in_req = mk_req(1'b0, 2'b01, 10'h0AA, 5'd9, 2'd1);
    @(posedge clk);
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL mr_held_count: got %0d expected 0", count); end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; out_ready = 1'b0; in_req = mk_req(1'b1, 2'b10, 10'h3C7, 5'd21, 2'd3);
    tick();
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL mr_new_count: got %0d expected 1", count); end
    n_checks++; if (out_req_id !== 5'd21) begin n_fail++; $display("FAIL mr_new_id: got %0d expected 21", out_req_id); end
    n_checks++; if (out_cmd !== 13'h1BC7) begin n_fail++; $display("FAIL mr_new_cmd: got %h expected 1bc7", out_cmd); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (obs_data !== exp_data) begin n_fail++; $display("FAIL mr_pop_data: got %h expected %h", obs_data, exp_data); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL mr_final_count: got %0d expected 0", count); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_fill();
    test_illegal();
    test_simultaneous();
    test_wrap();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before the sequence completed");
    $fatal(1, "watchdog");
  end

endmodule
